// File: rtl/regfile_host_port_if.sv
// Host-port bundle: byte command/readback streams plus the register-file
// write port and one registered read port.
interface regfile_host_port_if #(
  parameter int REGADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [REGADDR_WIDTH-1:0] readAddr;
  logic [DATA_WIDTH-1:0]    readData;
  logic [REGADDR_WIDTH-1:0] writeAddr;
  logic [DATA_WIDTH-1:0]    dataW;
  logic                     writeEnable;
  logic                     busy;
  logic                     cmd_err;

  modport slave (
    input  rx_data, rx_valid, tx_ready, readData,
    output rx_ready, tx_data, tx_valid, readAddr, writeAddr, dataW,
           writeEnable, busy, cmd_err
  );

  modport master (
    output rx_data, rx_valid, tx_ready, readData,
    input  rx_ready, tx_data, tx_valid, readAddr, writeAddr, dataW,
           writeEnable, busy, cmd_err
  );
endinterface

// File: rtl/regfile_host_port.sv
// Byte-stream command parser that bursts writes into the register file and
// streams read words back little-endian on the tx channel.
module regfile_host_port #(
  parameter int REGADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset,
  regfile_host_port_if.slave  bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [2:0] {HDR, CNT, WDATA, WSTROBE, RADDR, RCAP, RSEND} state_t;

  state_t                   state_q, state_d;
  logic                     dir_q, dir_d;
  logic [REGADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [BCW-1:0]           byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0]    asm_q, asm_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic [REGADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic [REGADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0]    data_w_q, data_w_d;
  logic                     rx_ready_q, rx_ready_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     write_en_q, write_en_d;
  logic                     busy_q, busy_d;
  logic                     cmd_err_q, cmd_err_d;
  logic                     rx_fire, tx_fire;

  assign rx_fire = bus.rx_valid && rx_ready_q;
  assign tx_fire = bus.tx_ready && tx_valid_q;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    shift_d      = shift_q;
    read_addr_d  = read_addr_q;
    write_addr_d = write_addr_q;
    data_w_d     = data_w_q;
    cmd_err_d    = 1'b0;

    case (state_q)
      HDR: begin
        if (rx_fire) begin
          if (bus.rx_data[6:5] != 2'b00) begin
            cmd_err_d = 1'b1;
          end else begin
            dir_d   = bus.rx_data[7];
            addr_d  = REGADDR_WIDTH'(bus.rx_data[4:0]);
            state_d = CNT;
          end
        end
      end
      CNT: begin
        if (rx_fire) begin
          cnt_d      = bus.rx_data;
          byte_cnt_d = '0;
          if (bus.rx_data == 8'd0) state_d = HDR;
          else if (dir_q)          state_d = WDATA;
          else                     state_d = RADDR;
        end
      end
      WDATA: begin
        if (rx_fire) begin
          // Shift in from the top so the first byte lands in bits 7:0.
          asm_d      = DATA_WIDTH'({bus.rx_data, asm_q} >> 8);
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d   = '0;
            write_addr_d = addr_q;
            data_w_d     = asm_d;
            state_d      = WSTROBE;
          end
        end
      end
      WSTROBE: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? HDR : WDATA;
      end
      RADDR: state_d = RCAP;
      RCAP: begin
        shift_d = bus.readData;
        state_d = RSEND;
      end
      RSEND: begin
        if (tx_fire) begin
          shift_d    = shift_q >> 8;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            addr_d     = addr_q + 1'b1;
            cnt_d      = cnt_q - 8'd1;
            state_d    = (cnt_q == 8'd1) ? HDR : RADDR;
          end
        end
      end
      default: state_d = HDR;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    rx_ready_d = (state_d == HDR) || (state_d == CNT) || (state_d == WDATA);
    write_en_d = (state_d == WSTROBE);
    tx_valid_d = (state_d == RSEND);
    busy_d     = (state_d != HDR);
    if (state_d == RADDR) read_addr_d = addr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HDR;
      dir_q        <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      shift_q      <= '0;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      data_w_q     <= '0;
      rx_ready_q   <= 1'b1;
      tx_valid_q   <= 1'b0;
      write_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      shift_q      <= shift_d;
      read_addr_q  <= read_addr_d;
      write_addr_q <= write_addr_d;
      data_w_q     <= data_w_d;
      rx_ready_q   <= rx_ready_d;
      tx_valid_q   <= tx_valid_d;
      write_en_q   <= write_en_d;
      busy_q       <= busy_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.tx_data     = shift_q[7:0];
  assign bus.tx_valid    = tx_valid_q;
  assign bus.readAddr    = read_addr_q;
  assign bus.writeAddr   = write_addr_q;
  assign bus.dataW       = data_w_q;
  assign bus.writeEnable = write_en_q;
  assign bus.busy        = busy_q;
  assign bus.cmd_err     = cmd_err_q;
endmodule
